// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared types for the pipeline stall/flush sequencer.
// Revision: 1.0
// ============================================================================
package pipeline_ctrl_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DWAIT  = 3'd1,
        HALTED = 3'd2
    } pipe_state_t;

    localparam regbits_t c_REG_ZERO = 5'd0;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_if
// Brief   : Hazard inputs and latch controls of pipeline_ctrl; counters under PIPE_PERF_EN.
// Revision: 1.0
// ============================================================================
interface pipeline_ctrl_if
`ifdef PIPE_PERF_EN
    #(parameter int CNT_W = 32)
`endif
    ();
    import pipeline_ctrl_pkg::*;

    logic        ihit;
    logic        dhit;
    logic        mem_dreq;
    logic        idex_memread;
    regbits_t    idex_rt;
    regbits_t    ifid_rs;
    regbits_t    ifid_rt;
    logic        br_taken;
    logic        halt_wb;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwb_flush;
    logic        halt;
    pipe_state_t state;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport pc (
        input  ihit, dhit, mem_dreq, idex_memread, idex_rt, ifid_rs, ifid_rt,
               br_taken, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, state
`ifdef PIPE_PERF_EN
        , output cyc_cnt, stall_cnt, flush_cnt
`endif
    );

    modport tb (
        output ihit, dhit, mem_dreq, idex_memread, idex_rt, ifid_rs, ifid_rt,
               br_taken, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, state
`ifdef PIPE_PERF_EN
        , input cyc_cnt, stall_cnt, flush_cnt
`endif
    );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module  : load_use_detect
// Brief   : Flags a load in ID/EX whose destination feeds the instruction in IF/ID.
// Revision: 1.0
// ============================================================================
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     memread_i,
    input  regbits_t idex_rt_i,
    input  regbits_t ifid_rs_i,
    input  regbits_t ifid_rt_i,
    output logic     lu_hazard_o
);

    // $zero is never a true dependency, so a load targeting it never stalls.
    assign lu_hazard_o = memread_i && (idex_rt_i != c_REG_ZERO) &&
                         ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Stall/flush sequencer for the 5-stage pipeline. Optional performance
//           counters are built when PIPE_PERF_EN is defined.
// Revision: 1.0
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int BR_STAGE = 3
`ifdef PIPE_PERF_EN
    , parameter int CNT_W  = 32
`endif
)
(
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.pc   bus
);

    localparam logic c_BR_FLUSH_EXMEM = (BR_STAGE == 3);

    pipe_state_t state_q, state_d;
    logic        squash_pend_q, squash_pend_d;

    logic lu_hazard;
    logic dstall;
    logic br_consumed;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic halt;

    load_use_detect u_lu (
        .memread_i   (bus.idex_memread),
        .idex_rt_i   (bus.idex_rt),
        .ifid_rs_i   (bus.ifid_rs),
        .ifid_rt_i   (bus.ifid_rt),
        .lu_hazard_o (lu_hazard)
    );

    // Once waiting, only dhit releases the stall, whatever mem_dreq does.
    assign dstall = (state_q == DWAIT) ? !bus.dhit : (bus.mem_dreq && !bus.dhit);

    always_comb begin
        state_d       = state_q;
        squash_pend_d = squash_pend_q;
        br_consumed   = 1'b0;
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        exmem_en      = 1'b0;
        memwb_en      = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        halt          = 1'b0;

        if (rst) begin
            state_d       = RUN;
            squash_pend_d = 1'b0;
        end else if ((state_q == HALTED) || bus.halt_wb) begin
            state_d = HALTED;
            halt    = 1'b1;
        end else if (dstall) begin
            state_d     = DWAIT;
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            state_d  = RUN;
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            // A redirect seen while waiting came from a held stage; take it when it recurs.
            if (bus.br_taken && (state_q != DWAIT)) begin
                br_consumed   = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                exmem_flush   = c_BR_FLUSH_EXMEM;
                squash_pend_d = !bus.ihit;
            end else if (lu_hazard) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                if (bus.ihit) begin
                    squash_pend_d = 1'b0;
                end
            end else if (!bus.ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end else if (squash_pend_q) begin
                // This hit answers the pre-redirect fetch: drop it and refetch the target.
                pc_en         = 1'b0;
                ifid_flush    = 1'b1;
                squash_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            squash_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            squash_pend_q <= squash_pend_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.halt        = halt;
    assign bus.state       = state_q;

`ifdef PIPE_PERF_EN
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cyc_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != HALTED) begin
            cyc_cnt_q <= cyc_cnt_q + c_ONE;
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + c_ONE;
            end
            if (br_consumed) begin
                flush_cnt_q <= flush_cnt_q + c_ONE;
            end
        end
    end

    assign bus.cyc_cnt   = cyc_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    logic unused_br;
    assign unused_br = br_consumed;
`endif

endmodule : pipeline_ctrl
`default_nettype wire
